pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Merges four hazard sources into one prioritised set of per-stage hold, bubble and flush controls:
  - data-memory wait,
  - multi-cycle MUL occupying EX,
  - taken branch resolved in EX,
  - load-use dependency.
- Also keeps saturating stall/flush performance counters and a data-memory wait watchdog.
- Sits beside the pipeline registers and drives their enable/clear inputs plus the PC write enable.

Parameters:
- REG_W, 3, register-index width.
- MUL_CYCLES, 4, EX occupancy of a MUL in cycles; legal range 2..15.
- CNT_W, 16, width of performance counters.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_timeout sets.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_W  destination of instruction in EX.
- if_id_rs1  in  REG_W  source 1 of instruction in ID.
- if_id_rs2  in  REG_W  source 2 of instruction in ID.
- id_is_mul  in  1  instruction in ID is a MUL.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- clr_cnt  in  1  synchronous clear of counters and mem_timeout.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_bubble  out  1  load NOP into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- mul_busy  out  1  FSM in MUL_BUSY.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating.
- flush_cnt  out  CNT_W  cycles with if_id_flush=1, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=RUN; mul_cnt, wait_cnt, stall_cnt and flush_cnt all 0; mem_timeout=0.
  - While rst_n=0, all control outputs are forced 0.
- Derived conditions, combinational, zero latency:
  - mem_stall = mem_req & ~mem_ready.
  - ex_hold = (state==MUL_BUSY) & (mul_cnt!=0).
  - load_use = id_ex_memread & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2). Register 0 is not excluded.
- Output priority (first match wins; unlisted outputs are 0):
  1. mem_stall: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble = 1.
  2. ex_hold: pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble = 1.
  3. ex_branch_taken: if_id_flush, id_ex_bubble = 1. PC not stalled. load_use is ignored because the ID instruction is squashed.
  4. load_use: pc_stall, if_id_stall, id_ex_bubble = 1.
- A branch under a higher-priority stall stays held in EX. Its flush is applied in the first cycle EX is free to advance.
- ID advances (id_adv) only when none of conditions 1–4 holds.
- FSM, two states:
  - RUN → MUL_BUSY when id_is_mul & id_adv. Load mul_cnt = MUL_CYCLES-1.
  - MUL_BUSY:
    - mul_cnt decrements by 1 each cycle, including during mem_stall, and freezes at 0.
    - When mul_cnt==0 & ~mem_stall, the MUL leaves EX.
    - On that exit: if id_is_mul & id_adv, stay in MUL_BUSY and reload MUL_CYCLES-1 (back-to-back MUL). Otherwise go to RUN.
  - mul_busy = (state==MUL_BUSY).
- Watchdog:
  - wait_cnt increments while mem_stall and clears to 0 when ~mem_stall; it saturates at MEM_TIMEOUT.
  - mem_timeout sets when wait_cnt reaches MEM_TIMEOUT. It stays set until reset or clr_cnt, and does not change stall behaviour.
- Counters:
  - stall_cnt increments on cycles with pc_stall=1.
  - flush_cnt increments on cycles with if_id_flush=1.
  - Both saturate at all-ones. clr_cnt has priority over increment.
- Reset mid-MUL or mid-wait: everything returns to reset values immediately. The interrupted MUL is not resumed.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants ST_RUN and ST_MUL_BUSY,
  - the default REG_W,
  - the output priority order as named constants for documentation and assertions.
- Sub-module sat_counter (parameter W; inputs inc and clr; output count) is instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=3, if_id_rs2=3 for one cycle → pc_stall=1, if_id_stall=1, id_ex_bubble=1, all others 0; stall_cnt 0→1.
- MUL (MUL_CYCLES=4): id_is_mul=1 with no hazard → next cycle mul_busy=1. ex_hold lasts 3 cycles (pc_stall=1, ex_mem_bubble=1). The 4th cycle advances and returns to RUN; stall_cnt=3.
- Branch vs load-use in the same cycle: ex_branch_taken=1 and load_use=1 → if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_cnt=1.
- Memory wait during MUL: mem_req=1, mem_ready=0 for 6 cycles starting at MUL entry → mem_wb_bubble=1 and ex_mem_stall=1 for 6 cycles, mul_cnt frozen at 0. Exit occurs on the first cycle with mem_ready=1.
- Watchdog (MEM_TIMEOUT=64): mem_stall held for 64 cycles → mem_timeout=1, staying 1 after mem_ready=1. A one-cycle clr_cnt pulse clears it along with both counters.
- Async reset: assert rst_n=0 mid-MUL with mul_cnt=2 → outputs go to 0 immediately without waiting for a clock edge. After release, state=RUN and mul_busy=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: FSM encoding, defaults and hazard priority order for the pipeline sequencer
package cpu_ctrl_pkg;
   typedef enum logic {ST_RUN = 1'b0, ST_MUL_BUSY = 1'b1} state_t;
   localparam int REG_W_DEF = 3;
   localparam int PRI_MEM = 0;
   localparam int PRI_EX = 1;
   localparam int PRI_BR = 2;
   localparam int PRI_LU = 3;
   localparam int PRI_N = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with clear taking priority over increment
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (clr) count <= '0;
      else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: prioritised stall/bubble/flush sequencer with MUL occupancy FSM, perf counters and memory watchdog
module pipe_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W       = REG_W_DEF,
   parameter int MUL_CYCLES  = 4,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_ex_memread,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             id_is_mul,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic             ex_mem_bubble,
   output logic             mem_wb_bubble,
   output logic             mul_busy,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);
   state_t state, state_nxt;
   logic [3:0] mul_cnt, mul_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [PRI_N-1:0] haz, win;
   logic mem_stall, ex_hold, load_use, id_adv, free, start;
   assign mem_stall = mem_req & ~mem_ready;
   assign ex_hold = (state == ST_MUL_BUSY) & (mul_cnt != 4'd0);
   assign load_use = id_ex_memread & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
   // lowest set bit is the winning hazard; everything is forced quiet while in reset
   always_comb begin
      haz = '0;
      haz[PRI_MEM] = mem_stall;
      haz[PRI_EX] = ex_hold;
      haz[PRI_BR] = ex_branch_taken;
      haz[PRI_LU] = load_use;
      win = rst_n ? (haz & (~haz + PRI_N'(1))) : '0;
      id_adv = ~|haz;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_RUN;
         mul_cnt <= '0;
      end else begin
         state <= state_nxt;
         mul_cnt <= mul_nxt;
      end
   // EX is free in RUN, or once the MUL count has drained and MEM is not holding it
   always_comb begin
      free = (state == ST_RUN) | ((mul_cnt == 4'd0) & ~mem_stall);
      start = id_is_mul & id_adv;
      state_nxt = free ? (start ? ST_MUL_BUSY : ST_RUN) : state;
      mul_nxt = (free & start) ? MUL_LD : ((mul_cnt != 4'd0) ? mul_cnt - 4'd1 : mul_cnt);
   end
   always_comb begin
      pc_stall = win[PRI_MEM] | win[PRI_EX] | win[PRI_LU];
      if_id_stall = win[PRI_MEM] | win[PRI_EX] | win[PRI_LU];
      if_id_flush = win[PRI_BR];
      id_ex_stall = win[PRI_MEM] | win[PRI_EX];
      id_ex_bubble = win[PRI_BR] | win[PRI_LU];
      ex_mem_stall = win[PRI_MEM];
      ex_mem_bubble = win[PRI_EX];
      mem_wb_bubble = win[PRI_MEM];
      mul_busy = state == ST_MUL_BUSY;
   end
   assign wait_nxt = mem_stall ? ((wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1)) : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wait_cnt <= '0;
         mem_timeout <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         mem_timeout <= ~clr_cnt & (mem_timeout | (wait_nxt == WW'(MEM_TIMEOUT)));
      end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst_n(rst_n), .inc(pc_stall), .clr(clr_cnt), .count(stall_cnt)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst_n(rst_n), .inc(if_id_flush), .clr(clr_cnt), .count(flush_cnt)
   );
endmodule
